// File: rtl/ttl_ff_bank.sv
// ---------------------------------------------------------------------------
// ttl_ff_bank
//
// Purpose: a bank of TTL-style edge-triggered flip-flops (D or JK type).
// Each chip clock, preset and clear is treated as an ordinary input and is
// sampled on the single system clock. A chip-clock rising edge is accepted
// only after it passes a glitch filter.
//
// Parameters:
//   CHANNELS : number of independent channels (own cclk/n_pre/n_clr each)
//   WIDTH    : bits per channel, sharing that channel's clock and controls
//   MODE     : 0 = D-type (k ignored), 1 = JK-type (J = d, K = k)
//   FILTER   : samples a chip clock must hold a new level (1..15)
//
// Ports:
//   clk      in   system clock, all state changes on its rising edge
//   n_reset  in   asynchronous active-low reset
//   cclk     in   [CHANNELS]        chip clock per channel (sampled level)
//   n_pre    in   [CHANNELS]        active-low preset per channel
//   n_clr    in   [CHANNELS]        active-low clear per channel
//   d        in   [CHANNELS*WIDTH]  D data, or J in JK mode
//   k        in   [CHANNELS*WIDTH]  K inputs (JK mode only)
//   q        out  [CHANNELS*WIDTH]  registered true outputs
//   n_q      out  [CHANNELS*WIDTH]  registered complement outputs
// ---------------------------------------------------------------------------
module ttl_ff_bank #(
   parameter int CHANNELS = 2,
   parameter int WIDTH    = 1,
   parameter int MODE     = 0,
   parameter int FILTER   = 1
) (
   input  logic                      clk,
   input  logic                      n_reset,
   input  logic [CHANNELS-1:0]       cclk,
   input  logic [CHANNELS-1:0]       n_pre,
   input  logic [CHANNELS-1:0]       n_clr,
   input  logic [CHANNELS*WIDTH-1:0] d,
   input  logic [CHANNELS*WIDTH-1:0] k,
   output logic [CHANNELS*WIDTH-1:0] q,
   output logic [CHANNELS*WIDTH-1:0] n_q
);

   localparam int            CW   = $clog2(FILTER + 1);
   localparam logic [CW-1:0] FILT = CW'(FILTER);

   genvar gi;
   generate
      for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
         logic             lvl_q, lvl_d;
         logic [CW-1:0]    cnt_q, cnt_d, cnt_inc;
         logic [WIDTH-1:0] capd_q, capd_d;
         logic [WIDTH-1:0] capk_q, capk_d;
         logic [WIDTH-1:0] out_q, out_d;
         logic [WIDTH-1:0] nout_q, nout_d;
         logic [WIDTH-1:0] d_ch, k_ch;
         logic [WIDTH-1:0] ev_d, ev_k, ev_q;
         logic             start;
         logic             rise;

         assign d_ch    = d[gi*WIDTH +: WIDTH];
         assign k_ch    = k[gi*WIDTH +: WIDTH];
         assign cnt_inc = cnt_q + CW'(1);

         // First high sample of a rising attempt: this is where the real chip
         // would have seen its edge, so data is captured here.
         assign start = cclk[gi] && !lvl_q && (cnt_q == '0);

         // With FILTER=1 the capture and the event fall on the same edge, so
         // the live inputs are used instead of the not-yet-written capture.
         assign ev_d = start ? d_ch : capd_q;
         assign ev_k = start ? k_ch : capk_q;

         // Glitch filter and capture register.
         always_comb begin
            lvl_d  = lvl_q;
            cnt_d  = cnt_q;
            capd_d = capd_q;
            capk_d = capk_q;
            rise   = 1'b0;
            if (cclk[gi] == lvl_q) begin
               // Matches the accepted level (or an attempt was aborted).
               cnt_d = '0;
            end else if (cnt_inc == FILT) begin
               lvl_d = ~lvl_q;
               cnt_d = '0;
               rise  = ~lvl_q;
            end else begin
               cnt_d = cnt_inc;
            end
            if (start) begin
               capd_d = d_ch;
               capk_d = k_ch;
            end
         end

         // Flip-flop action for a clock event.
         always_comb begin
            ev_q = out_q;
            for (int b = 0; b < WIDTH; b++) begin
               if (MODE == 0) begin
                  ev_q[b] = ev_d[b];
               end else begin
                  case ({ev_d[b], ev_k[b]})
                     2'b00:   ev_q[b] = out_q[b];
                     2'b01:   ev_q[b] = 1'b0;
                     2'b10:   ev_q[b] = 1'b1;
                     default: ev_q[b] = ~out_q[b];
                  endcase
               end
            end
         end

         // Preset/clear override clock events; both low drives q and n_q
         // high like a real 74LS74. Otherwise n_q always follows ~q, which
         // also restores the complement on release.
         always_comb begin
            out_d  = out_q;
            nout_d = nout_q;
            if (!n_pre[gi] && !n_clr[gi]) begin
               out_d  = '1;
               nout_d = '1;
            end else if (!n_pre[gi]) begin
               out_d  = '1;
               nout_d = '0;
            end else if (!n_clr[gi]) begin
               out_d  = '0;
               nout_d = '1;
            end else begin
               out_d  = rise ? ev_q : out_q;
               nout_d = ~out_d;
            end
         end

         always_ff @(posedge clk or negedge n_reset) begin
            if (!n_reset) begin
               lvl_q  <= 1'b1;
               cnt_q  <= '0;
               capd_q <= '0;
               capk_q <= '0;
               out_q  <= '0;
               nout_q <= '1;
            end else begin
               lvl_q  <= lvl_d;
               cnt_q  <= cnt_d;
               capd_q <= capd_d;
               capk_q <= capk_d;
               out_q  <= out_d;
               nout_q <= nout_d;
            end
         end

         assign q[gi*WIDTH +: WIDTH]   = out_q;
         assign n_q[gi*WIDTH +: WIDTH] = nout_q;
      end
   endgenerate

endmodule

// File: tb/tb_ttl_ff_bank.sv
// ---------------------------------------------------------------------------
// tb_ttl_ff_bank
//
// Two instances share clk and n_reset:
//   u_jk : JK mode, 4 channels x 4 bits, FILTER=1 (table-driven vectors)
//   u_d  : D mode, 2 channels x 1 bit, FILTER=3 (hand-written sequences)
// Inputs change on the falling edge; outputs are compared on the next
// falling edge, i.e. after the rising edge that sampled the inputs.
// ---------------------------------------------------------------------------
module tb_ttl_ff_bank;

   logic        clk;
   logic        n_reset;

   logic [3:0]  jk_cclk, jk_pre, jk_clr;
   logic [15:0] jk_d, jk_k, jk_q, jk_nq;

   logic [1:0]  dc_cclk, dc_pre, dc_clr, dc_d, dc_k, dc_q, dc_nq;

   int checks = 0;
   int errors = 0;

   ttl_ff_bank #(.CHANNELS(4), .WIDTH(4), .MODE(1), .FILTER(1)) u_jk (
      .clk     (clk),
      .n_reset (n_reset),
      .cclk    (jk_cclk),
      .n_pre   (jk_pre),
      .n_clr   (jk_clr),
      .d       (jk_d),
      .k       (jk_k),
      .q       (jk_q),
      .n_q     (jk_nq)
   );

   ttl_ff_bank #(.CHANNELS(2), .WIDTH(1), .MODE(0), .FILTER(3)) u_d (
      .clk     (clk),
      .n_reset (n_reset),
      .cclk    (dc_cclk),
      .n_pre   (dc_pre),
      .n_clr   (dc_clr),
      .d       (dc_d),
      .k       (dc_k),
      .q       (dc_q),
      .n_q     (dc_nq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [3:0]  cclk;
      logic [3:0]  pre;
      logic [3:0]  clr;
      logic [15:0] d;
      logic [15:0] k;
      logic [15:0] q;
      logic [15:0] nq;
   } vec_t;

   vec_t vecs [14];

   initial begin
      // JK vectors, FILTER=1: an event happens on the edge cclk goes 0->1.
      // Channel c occupies bits [4c+3:4c].
      vecs[0]  = '{4'h0, 4'hF, 4'hF, 16'h0000, 16'h0000, 16'h0000, 16'hFFFF}; // filtered level falls
      vecs[1]  = '{4'h1, 4'hF, 4'hF, 16'h000C, 16'h000A, 16'h000C, 16'hFFF3}; // J=1100 K=1010 from 0000
      vecs[2]  = '{4'h0, 4'hF, 4'hF, 16'h000C, 16'h000A, 16'h000C, 16'hFFF3}; // falling: no event
      vecs[3]  = '{4'h1, 4'hF, 4'hF, 16'h000C, 16'h000A, 16'h0004, 16'hFFFB}; // again from 1100
      vecs[4]  = '{4'h0, 4'h9, 4'hF, 16'h0000, 16'h0000, 16'h0FF4, 16'hF00B}; // preset ch1, ch2
      vecs[5]  = '{4'h0, 4'hF, 4'hF, 16'h0000, 16'h0000, 16'h0FF4, 16'hF00B}; // release holds
      vecs[6]  = '{4'h9, 4'hF, 4'hD, 16'hF000, 16'h000F, 16'hFF00, 16'h00FF}; // ev ch0/ch3, clr ch1
      vecs[7]  = '{4'h0, 4'hF, 4'hF, 16'h0000, 16'h0000, 16'hFF00, 16'h00FF};
      vecs[8]  = '{4'h1, 4'hE, 4'hE, 16'h0000, 16'h000F, 16'hFF0F, 16'h00FF}; // both low + event
      vecs[9]  = '{4'h0, 4'hE, 4'hE, 16'h0000, 16'h000F, 16'hFF0F, 16'h00FF};
      vecs[10] = '{4'h1, 4'hE, 4'hE, 16'h0000, 16'h000F, 16'hFF0F, 16'h00FF}; // event ignored
      vecs[11] = '{4'h0, 4'hE, 4'hE, 16'h0000, 16'h000F, 16'hFF0F, 16'h00FF};
      vecs[12] = '{4'h0, 4'hF, 4'hF, 16'h0000, 16'h000F, 16'hFF0F, 16'h00F0}; // release both: q=1 n_q=0
      vecs[13] = '{4'h1, 4'hF, 4'hF, 16'h0000, 16'h000F, 16'hFF00, 16'h00FF}; // K clears ch0

      // Reset with chip clocks and data high.
      n_reset = 1'b0;
      jk_cclk = 4'hF; jk_pre = 4'hF; jk_clr = 4'hF; jk_d = '0; jk_k = '0;
      dc_cclk = 2'b11; dc_pre = 2'b11; dc_clr = 2'b11; dc_d = 2'b11; dc_k = 2'b00;
      repeat (3) @(negedge clk);
      n_reset = 1'b1;

      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk($sformatf("reset_q_%0d", i), {14'd0, dc_q}, 16'h0000);
         chk($sformatf("reset_nq_%0d", i), {14'd0, dc_nq}, 16'h0003);
         $display("reset cycle %0d d_q=%b d_nq=%b", i, dc_q, dc_nq);
      end
      chk("jk_reset_q", jk_q, 16'h0000);
      chk("jk_reset_nq", jk_nq, 16'hFFFF);

      // JK table.
      for (int i = 0; i < 14; i++) begin
         jk_cclk = vecs[i].cclk;
         jk_pre  = vecs[i].pre;
         jk_clr  = vecs[i].clr;
         jk_d    = vecs[i].d;
         jk_k    = vecs[i].k;
         @(negedge clk);
         chk($sformatf("jk_q_vec%0d", i), jk_q, vecs[i].q);
         chk($sformatf("jk_nq_vec%0d", i), jk_nq, vecs[i].nq);
         $display("vec %0d cclk=%h pre=%h clr=%h q=%h n_q=%h", i, jk_cclk, jk_pre, jk_clr, jk_q, jk_nq);
      end

      // D mode, FILTER=3: bring both filtered levels low.
      dc_cclk = 2'b00; dc_d = 2'b00;
      repeat (3) @(negedge clk);
      chk("d_low_q", {14'd0, dc_q}, 16'h0000);

      // Capture at edge n with d=1, d drops afterwards; q rises at n+2.
      dc_cclk = 2'b01; dc_d = 2'b01;
      @(negedge clk);
      chk("d_cap_n", {14'd0, dc_q}, 16'h0000);
      $display("d capture edge n q=%b", dc_q);
      dc_d = 2'b00;
      @(negedge clk);
      chk("d_cap_n1", {14'd0, dc_q}, 16'h0000);
      $display("d capture edge n+1 q=%b", dc_q);
      @(negedge clk);
      chk("d_cap_n2_q", {14'd0, dc_q}, 16'h0001);
      chk("d_cap_n2_nq", {14'd0, dc_nq}, 16'h0002);
      $display("d capture edge n+2 q=%b n_q=%b", dc_q, dc_nq);

      // Channel 1: 2-cycle glitch (d=0) is rejected.
      dc_cclk = 2'b11; dc_d = 2'b00;
      repeat (2) @(negedge clk);
      chk("glitch_hi", {14'd0, dc_q}, 16'h0001);
      dc_cclk = 2'b01;
      @(negedge clk);
      chk("glitch_drop", {14'd0, dc_q}, 16'h0001);
      $display("glitch rejected q=%b", dc_q);

      // Full pulse recaptures d=1 at its first sample.
      dc_cclk = 2'b11; dc_d = 2'b10;
      @(negedge clk);
      chk("pulse_1", {14'd0, dc_q}, 16'h0001);
      dc_d = 2'b00;
      @(negedge clk);
      chk("pulse_2", {14'd0, dc_q}, 16'h0001);
      @(negedge clk);
      chk("pulse_3_q", {14'd0, dc_q}, 16'h0003);
      chk("pulse_3_nq", {14'd0, dc_nq}, 16'h0000);
      $display("pulse accepted q=%b n_q=%b", dc_q, dc_nq);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
